// File: rtl/dm_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, MMIO map
// and small address-decode helpers.
package dm_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0]  MMIO_BASE = 4'hF;
  localparam logic [27:0] OFF_LED   = 28'h000_0000;
  localparam logic [27:0] OFF_CYCLE = 28'h000_0004;

  function automatic logic is_mmio(input logic [3:0] nib);
    return (nib == MMIO_BASE);
  endfunction

  // Word-granular offset match; byte bits of the address never take part.
  function automatic logic off_hit(input logic [25:0] word_off, input logic [27:0] off);
    return ({word_off, 2'b00} == off);
  endfunction

endpackage

// File: rtl/dm_ram.sv
// Word-wide RAM with per-byte write enables and a combinational read port;
// the parent registers the read data.
module dm_ram #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic [3:0]            we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [31:0]           rdata
);

  logic [31:0] mem_r [0:(1 << DEPTH_LOG2) - 1];

  // Byte-lane writes; storage is intentionally not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem_r[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: RAM plus LED/CYCLE MMIO behind a req/ready handshake
// with a configurable number of wait states.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        mem_w,
  input  logic [3:0]  wea,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [31:0] led
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic [31:0] addr_r;
  logic        mem_w_r;
  logic [3:0]  wea_r;
  logic [31:0] wdata_r;
  logic        ready_r;
  logic [31:0] rdata_r;
  logic [31:0] led_r;
  logic [31:0] cycle_r;

  logic [31:0] acc_addr_s;
  logic        acc_mem_w_s;
  logic [31:0] ram_rdata_s;
  logic [31:0] read_val_s;
  logic        enter_resp_s;
  logic        commit_s;
  logic [3:0]  ram_we_s;
  logic        led_we_s;
  logic        unused_addr_s;

  // With zero wait states RESP is entered on the sampling edge, so the live
  // request fields must feed the read path while still in IDLE.
  always_comb begin
    if (state_r == ST_IDLE) begin
      acc_addr_s  = addr;
      acc_mem_w_s = mem_w;
    end else begin
      acc_addr_s  = addr_r;
      acc_mem_w_s = mem_w_r;
    end
  end

  assign unused_addr_s = ^acc_addr_s[1:0];

  dm_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (addr_r[DEPTH_LOG2+1:2]),
    .wdata (wdata_r),
    .raddr (acc_addr_s[DEPTH_LOG2+1:2]),
    .rdata (ram_rdata_s)
  );

  // Read-data source selection: RAM, LED, CYCLE or zero for unmapped MMIO.
  always_comb begin
    read_val_s = 32'h0000_0000;
    if (is_mmio(acc_addr_s[31:28])) begin
      if (off_hit(acc_addr_s[27:2], OFF_LED)) begin
        read_val_s = led_r;
      end else if (off_hit(acc_addr_s[27:2], OFF_CYCLE)) begin
        read_val_s = cycle_r;
      end else begin
        read_val_s = 32'h0000_0000;
      end
    end else begin
      read_val_s = ram_rdata_s;
    end
  end

  // Detects the edge that moves the FSM into RESP.
  always_comb begin
    enter_resp_s = 1'b0;
    case (state_r)
      ST_IDLE: enter_resp_s = req && (WAIT_INIT == 4'd0);
      ST_WAIT: enter_resp_s = req && (cnt_r == 4'd1);
      default: enter_resp_s = 1'b0;
    endcase
  end

  // Write strobes, active only during RESP so they land on its closing edge.
  always_comb begin
    commit_s = (state_r == ST_RESP) && mem_w_r;
    ram_we_s = 4'b0000;
    led_we_s = 1'b0;
    if (commit_s && !is_mmio(addr_r[31:28])) begin
      ram_we_s = wea_r;
    end else begin
      led_we_s = commit_s && off_hit(addr_r[27:2], OFF_LED);
    end
  end

  // Handshake FSM with registered ready pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      ready_r <= 1'b0;
      addr_r  <= 32'h0000_0000;
      mem_w_r <= 1'b0;
      wea_r   <= 4'b0000;
      wdata_r <= 32'h0000_0000;
    end else begin
      ready_r <= enter_resp_s;
      case (state_r)
        ST_IDLE: begin
          if (req) begin
            addr_r  <= addr;
            mem_w_r <= mem_w;
            wea_r   <= wea;
            wdata_r <= wdata;
            if (WAIT_INIT == 4'd0) begin
              state_r <= ST_RESP;
              cnt_r   <= 4'd0;
            end else begin
              state_r <= ST_WAIT;
              cnt_r   <= WAIT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (!req) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
          end else if (cnt_r == 4'd1) begin
            state_r <= ST_RESP;
            cnt_r   <= 4'd0;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

  // Read data captured on RESP entry and held across writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_r <= 32'h0000_0000;
    end else if (enter_resp_s && !acc_mem_w_s) begin
      rdata_r <= read_val_s;
    end
  end

  // LED register with byte enables.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_r <= 32'h0000_0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (led_we_s && wea_r[i]) begin
          led_r[8*i +: 8] <= wdata_r[8*i +: 8];
        end
      end
    end
  end

  // Free-running cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_r <= 32'h0000_0000;
    end else begin
      cycle_r <= cycle_r + 32'd1;
    end
  end

  assign rdata = rdata_r;
  assign ready = ready_r;
  assign led   = led_r;

endmodule
